// File: rtl/common.sv
// Shared sizing helpers for the core.
// Register-index widths derived from NREG.
package common;
  localparam int NREG_DFLT = 32;
  localparam int RW = $clog2(NREG_DFLT);

  function automatic int regw(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/pipes.sv
// Inter-stage types shared by the pipeline.
// Forward selects, write kinds, hazard records.
package pipes;
  import common::*;

  typedef enum logic [2:0] {
    FW_REGFILE = 3'd0,
    FW_RESULT  = 3'd1,
    FW_WD      = 3'd2,
    FW_PCPLUS4 = 3'd3,
    FW_SREGWD  = 3'd4
  } forward_t;

  typedef enum logic [1:0] {
    WK_ALU  = 2'd0,
    WK_LOAD = 2'd1,
    WK_LINK = 2'd2,
    WK_CSR  = 2'd3
  } wkind_t;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    wkind_t        kind;
  } hz_rec_t;

  localparam hz_rec_t REC_NONE = '{
    valid: 1'b0,
    rd:    '0,
    kind:  WK_ALU
  };
endpackage

// File: rtl/hz_match.sv
// Per-source forward select and load-use detect.
// Execute record beats Memory record; x0 never hits.
module hz_match
  import common::*, pipes::*;
(
  input  logic [RW-1:0] src,
  input  hz_rec_t       e,
  input  hz_rec_t       m,
  output forward_t      sel,
  output logic          lu
);

  // Pick the youngest producer of src
  always_comb begin
    sel = FW_REGFILE;
    lu  = 1'b0;
    if (src != '0) begin
      if (e.valid && e.rd == src) begin
        unique case (e.kind)
          WK_ALU:  sel = FW_RESULT;
          WK_LINK: sel = FW_PCPLUS4;
          WK_CSR:  sel = FW_SREGWD;
          WK_LOAD: lu  = 1'b1;
          default: sel = FW_REGFILE;
        endcase
      end else if (m.valid && m.rd == src) begin
        sel = FW_WD;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding and stall scheduler.
// Tracks E/M write records; registers fwd selects.
module hazard_unit
  import common::*, pipes::*;
#(
  parameter int NREG = NREG_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [regw(NREG)-1:0] d_rs1,
  input  logic [regw(NREG)-1:0] d_rs2,
  input  logic [regw(NREG)-1:0] d_rd,
  input  logic                  d_wen,
  input  logic [1:0]            d_kind,
  input  logic                  flush,
  input  logic                  mem_wait,
  output logic                  stall_fd,
  output logic                  bubble_e,
  output logic                  freeze,
  output logic [2:0]            fwd_a,
  output logic [2:0]            fwd_b
);

  hz_rec_t  e_rec;
  hz_rec_t  m_rec;
  hz_rec_t  d_rec;
  logic     flush_pend;
  forward_t sel_a;
  forward_t sel_b;
  logic     lu_a;
  logic     lu_b;
  logic     adv;
  logic     kill;
  logic     load_use;

  hz_match u_match_a (
    .src (d_rs1),
    .e   (e_rec),
    .m   (m_rec),
    .sel (sel_a),
    .lu  (lu_a)
  );

  hz_match u_match_b (
    .src (d_rs2),
    .e   (e_rec),
    .m   (m_rec),
    .sel (sel_b),
    .lu  (lu_b)
  );

  // Stall/bubble/freeze decode; flush beats load-use
  always_comb begin
    d_rec.valid = d_valid && d_wen && (d_rd != '0);
    d_rec.rd    = d_rd;
    d_rec.kind  = wkind_t'(d_kind);
    adv         = !mem_wait;
    kill        = flush || flush_pend;
    load_use    = d_valid && (lu_a || lu_b);
    freeze      = mem_wait;
    stall_fd    = adv && !kill && load_use;
    bubble_e    = adv && !kill && load_use;
  end

  // Advance records and selects unless frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rec      <= REC_NONE;
      m_rec      <= REC_NONE;
      flush_pend <= 1'b0;
      fwd_a      <= FW_REGFILE;
      fwd_b      <= FW_REGFILE;
    end else if (adv) begin
      m_rec      <= e_rec;
      flush_pend <= 1'b0;
      if (kill || load_use) begin
        e_rec <= REC_NONE;
        fwd_a <= FW_REGFILE;
        fwd_b <= FW_REGFILE;
      end else begin
        e_rec <= d_rec;
        fwd_a <= sel_a;
        fwd_b <= sel_b;
      end
    end else begin
      flush_pend <= flush_pend || flush;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit.
// Reference: list of in-flight writers, newest first.
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic [4:0] d_rd;
  logic       d_wen;
  logic [1:0] d_kind;
  logic       flush;
  logic       mem_wait;
  logic       stall_fd;
  logic       bubble_e;
  logic       freeze;
  logic [2:0] fwd_a;
  logic [2:0] fwd_b;

  hazard_unit #(.NREG(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_rs1    (d_rs1),
    .d_rs2    (d_rs2),
    .d_rd     (d_rd),
    .d_wen    (d_wen),
    .d_kind   (d_kind),
    .flush    (flush),
    .mem_wait (mem_wait),
    .stall_fd (stall_fd),
    .bubble_e (bubble_e),
    .freeze   (freeze),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd;
    int k;
  } prec_t;

  prec_t      inflight[$];
  bit         pend;
  int         efa;
  int         efb;
  logic [2:0] comb_q[$];
  logic [5:0] fwd_q[$];
  int         checks;
  int         errors;

  localparam int LU = 7;

  function automatic int look(input int s);
    if (s == 0) return 0;
    if (inflight[0].v && inflight[0].rd == s) begin
      case (inflight[0].k)
        0: return 1;
        1: return LU;
        2: return 3;
        default: return 4;
      endcase
    end
    if (inflight[1].v && inflight[1].rd == s) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    prec_t none;
    none = '{v: 1'b0, rd: 0, k: 0};
    inflight.delete();
    inflight.push_back(none);
    inflight.push_back(none);
    pend = 1'b0;
    efa = 0;
    efb = 0;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2,
                       input int rd, input bit wen, input int k,
                       input bit fl, input bit mw);
    d_valid  = v;
    d_rs1    = 5'(rs1);
    d_rs2    = 5'(rs2);
    d_rd     = 5'(rd);
    d_wen    = wen;
    d_kind   = 2'(k);
    flush    = fl;
    mem_wait = mw;
  endtask

  task automatic cyc(input bit v, input int rs1, input int rs2,
                     input int rd, input bit wen, input int k,
                     input bit fl, input bit mw);
    int la;
    int lb;
    bit lu;
    bit kill;
    bit st;
    prec_t nr;
    @(negedge clk);
    drive(v, rs1, rs2, rd, wen, k, fl, mw);
    #1;
    la   = look(rs1);
    lb   = look(rs2);
    lu   = v && (la == LU || lb == LU);
    kill = fl || pend;
    st   = !mw && !kill && lu;
    comb_q.push_back({st, st, mw});
    if (!mw) begin
      if (kill || lu) begin
        nr  = '{v: 1'b0, rd: 0, k: 0};
        efa = 0;
        efb = 0;
      end else begin
        nr  = '{v: v && wen && rd != 0, rd: rd, k: k};
        efa = (la == LU) ? 0 : la;
        efb = (lb == LU) ? 0 : lb;
      end
      inflight.push_front(nr);
      void'(inflight.pop_back());
      pend = 1'b0;
    end else begin
      pend = pend || fl;
    end
    fwd_q.push_back({3'(efa), 3'(efb)});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: comb outputs mid-low phase, selects after edge
  initial begin
    logic [2:0] ec;
    logic [5:0] ef;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        ec = comb_q.pop_front();
        checks++;
        if ({stall_fd, bubble_e, freeze} !== ec) begin
          errors++;
          $display("FAIL comb t=%0t got s/b/f=%b want %b",
                   $time, {stall_fd, bubble_e, freeze}, ec);
        end
      end
      @(posedge clk);
      #1;
      if (fwd_q.size() > 0) begin
        ef = fwd_q.pop_front();
        checks++;
        if ({fwd_a, fwd_b} !== ef) begin
          errors++;
          $display("FAIL fwd t=%0t got a=%0d b=%0d want a=%0d b=%0d",
                   $time, fwd_a, fwd_b, ef[5:3], ef[2:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    #1;
    checks++;
    if ({stall_fd, bubble_e, freeze, fwd_a, fwd_b} !== 9'b001_000_000) begin
      errors++;
      $display("FAIL reset_state got %b want %b",
               {stall_fd, bubble_e, freeze, fwd_a, fwd_b}, 9'b001_000_000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // ALU x5 -> reader rs1: Result / Regfile
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(1, 5, 6, 8, 1, 0, 0, 0);
    idle();
    // ALU x5, independent, reader: Wd
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(1, 1, 2, 9, 1, 0, 0, 0);
    cyc(1, 5, 0, 10, 1, 0, 0, 0);
    idle();
    // lw x7 then reader rs2: one stall, then Wd
    cyc(1, 1, 2, 7, 1, 1, 0, 0);
    cyc(1, 3, 7, 10, 1, 0, 0, 0);
    cyc(1, 3, 7, 10, 1, 0, 0, 0);
    idle();
    // back-to-back loads and load + independent
    cyc(1, 0, 0, 7, 1, 1, 0, 0);
    cyc(1, 7, 0, 8, 1, 1, 0, 0);
    cyc(1, 7, 0, 8, 1, 1, 0, 0);
    cyc(1, 8, 0, 9, 1, 0, 0, 0);
    cyc(1, 8, 0, 9, 1, 0, 0, 0);
    cyc(1, 1, 2, 11, 1, 1, 0, 0);
    cyc(1, 3, 4, 12, 1, 0, 0, 0);
    idle();
    // jal x1, csrrw x3, write to x0
    cyc(1, 0, 0, 1, 1, 2, 0, 0);
    cyc(1, 1, 0, 4, 1, 0, 0, 0);
    idle();
    cyc(1, 0, 0, 3, 1, 3, 0, 0);
    cyc(1, 0, 3, 4, 1, 0, 0, 0);
    idle();
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4, 1, 0, 0, 0);
    idle();
    // freeze 3 cycles, flush in the 2nd
    cyc(1, 1, 2, 5, 1, 0, 0, 0);
    cyc(1, 5, 5, 6, 1, 0, 0, 1);
    cyc(1, 5, 5, 6, 1, 0, 1, 1);
    cyc(1, 5, 5, 6, 1, 0, 0, 1);
    cyc(1, 5, 5, 6, 1, 0, 0, 0);
    cyc(1, 6, 5, 7, 1, 0, 0, 0);
    idle();
    // flush against a load-use stall
    cyc(1, 0, 0, 9, 1, 1, 0, 0);
    cyc(1, 9, 9, 2, 1, 0, 1, 0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end
    idle();
    idle();

    // reset asserted in the middle of a load-use stall
    cyc(1, 1, 2, 7, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 3, 7, 10, 1, 0, 0, 0);
    #3;
    checks++;
    if ({stall_fd, bubble_e} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_stall got %b want 11",
               {stall_fd, bubble_e});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({stall_fd, bubble_e, freeze, fwd_a, fwd_b} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset got %b want %b",
               {stall_fd, bubble_e, freeze, fwd_a, fwd_b}, 9'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc(1, 3, 7, 10, 1, 0, 0, 0);
    idle();
    idle();
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (comb_q.size() != 0 || fwd_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d left want 0/0",
               comb_q.size(), fwd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
